// File: rtl/reset_ctrl_if.sv
// reset_ctrl_if: pin-side bundle of the reset controller.
// master = board/bench side driving the raw sources and watchdog controls;
// slave  = reset_ctrl side producing the core reset and status.
interface reset_ctrl_if #(
  parameter int unsigned SOURCES = 2
);
  logic [SOURCES-1:0] src_in;
  logic               wdt_en;
  logic               wdt_kick;
  logic               res_out;
  logic               resn_out;
  logic [SOURCES-1:0] cause;
  logic               wdt_fired;
  logic [7:0]         res_count;

  modport master (
    output src_in, wdt_en, wdt_kick,
    input  res_out, resn_out, cause, wdt_fired, res_count
  );

  modport slave (
    input  src_in, wdt_en, wdt_kick,
    output res_out, resn_out, cause, wdt_fired, res_count
  );
endinterface

// File: rtl/reset_ctrl.sv
// reset_ctrl: merges SOURCES reset inputs into one registered core reset.
// Each source is synchronised, optionally debounced and pulse-stretched, and
// the block keeps sticky cause flags plus a saturating reset counter.
// Optional watchdog: define RESET_WDT_EN to build it; otherwise wdt_en and
// wdt_kick are ignored and wdt_fired reads 0.
module reset_ctrl #(
  parameter int unsigned        SOURCES         = 2,
  parameter logic [SOURCES-1:0] ACTIVE_LOW      = 2'b11,
  parameter logic [SOURCES-1:0] STRETCH_MASK    = 2'b01,
  parameter int unsigned        SYNC_STAGES     = 2,
  parameter int unsigned        DEBOUNCE_CYCLES = 1600000,
  parameter int unsigned        PULSE_CYCLES    = 8000000,
  parameter int unsigned        WDT_CYCLES      = 16000000
) (
  input  logic         clock_160,
  input  logic         res,
  reset_ctrl_if.slave  bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  typedef enum logic [1:0] {S_POR, S_RUN, S_ASSERT, S_HOLD} state_t;

  logic [SOURCES-1:0] act;
  logic [SOURCES-1:0] deb;
  logic               trig;
  logic               stretch_hit;
  logic               wdt_to;

  state_t             state;
  logic [PW-1:0]      pulse_cnt;
  logic               res_q;
  logic [SOURCES-1:0] cause_q;
  logic [7:0]         count_q;

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q;

    // Synchroniser chain, parked at the source's idle pin level
    always_ff @(posedge clock_160 or posedge res) begin
      if (res) sync_q <= {SYNC_STAGES{ACTIVE_LOW[i]}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.src_in[i]};
    end

    assign act[i] = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW[i];

    if (STRETCH_MASK[i]) begin : g_deb
      logic          deb_q;
      logic [DW-1:0] deb_cnt;

      // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES in a row
      always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
          deb_q   <= 1'b0;
          deb_cnt <= '0;
        end else if (act[i] == deb_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q   <= act[i];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end

      assign deb[i] = deb_q;
    end else begin : g_byp
      assign deb[i] = act[i];
    end
  end

`ifdef RESET_WDT_EN
  logic [WW-1:0] wdt_cnt;
  logic          wdt_fired_q;

  // Kick has priority so a reload on the terminal cycle still averts the timeout
  assign wdt_to = (state == S_RUN) && bus.wdt_en && !bus.wdt_kick &&
                  (wdt_cnt == WW'(WDT_CYCLES - 1));

  // Watchdog counter: advances only while running and enabled
  always_ff @(posedge clock_160 or posedge res) begin
    if (res)                                            wdt_cnt <= '0;
    else if (state != S_RUN || bus.wdt_kick || wdt_to) wdt_cnt <= '0;
    else if (bus.wdt_en)                                wdt_cnt <= wdt_cnt + 1'b1;
  end

  assign bus.wdt_fired = wdt_fired_q;
`else
  logic wdt_unused;
  assign wdt_unused    = ^{bus.wdt_en, bus.wdt_kick, WDT_CYCLES[0]};
  assign wdt_to        = 1'b0;
  assign bus.wdt_fired = 1'b0;
`endif

  // Trigger summary for the sequencer
  always_comb begin
    trig        = (|deb) || wdt_to;
    stretch_hit = |(deb & STRETCH_MASK);
  end

  // Reset sequencer; res_out lags the state by one cycle and also covers the
  // cycle in which RUN accepts a trigger
  always_ff @(posedge clock_160 or posedge res) begin
    if (res) begin
      state     <= S_POR;
      pulse_cnt <= PW'(PULSE_CYCLES - 1);
      res_q     <= 1'b1;
      cause_q   <= '0;
      count_q   <= '0;
`ifdef RESET_WDT_EN
      wdt_fired_q <= 1'b0;
`endif
    end else begin
      res_q <= (state != S_RUN) || trig;
      case (state)
        S_POR: begin
          if (pulse_cnt == '0) begin
            if (trig) state <= S_HOLD;
            else      state <= S_RUN;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (trig) begin
            cause_q <= deb;
            if (count_q != '1) count_q <= count_q + 1'b1;
`ifdef RESET_WDT_EN
            wdt_fired_q <= wdt_to;
`endif
            if (stretch_hit || wdt_to) begin
              state     <= S_ASSERT;
              pulse_cnt <= PW'(PULSE_CYCLES - 1);
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_ASSERT: begin
          cause_q <= cause_q | deb;
          if (pulse_cnt == '0) begin
            if (trig) state <= S_HOLD;
            else      state <= S_RUN;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (!trig) state <= S_RUN;
        end
        default: state <= S_POR;
      endcase
    end
  end

  assign bus.res_out   = res_q;
  assign bus.resn_out  = ~res_q;
  assign bus.cause     = cause_q;
  assign bus.res_count = count_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// tb_reset_ctrl: directed stimulus for reset_ctrl. Stimulus pushes the
// expected res_out edges (cycle, cause, count, wdt_fired) into a queue; the
// monitor pops one entry per observed res_out transition and compares.
module tb_reset_ctrl;

  logic clock_160 = 1'b0;
  logic res;

  always #5 clock_160 = ~clock_160;

  reset_ctrl_if #(.SOURCES(2)) rc_bus ();

  reset_ctrl #(
    .SOURCES        (2),
    .ACTIVE_LOW     (2'b11),
    .STRETCH_MASK   (2'b01),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (10),
    .WDT_CYCLES     (20)
  ) dut (
    .clock_160(clock_160),
    .res      (res),
    .bus      (rc_bus)
  );

  typedef struct {
    string       name;
    logic        lvl;
    int unsigned at;
    logic [1:0]  cause;
    logic [7:0]  count;
    logic        wdt;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  logic        mon_en = 1'b0;
  logic        prev   = 1'b1;
  logic [7:0]  exp_cnt;

  always @(posedge clock_160) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic expect_edge(input string nm, input logic lvl, input int unsigned at,
                             input logic [1:0] c, input logic [7:0] n, input logic w);
    exp_t e;
    e.name  = nm;
    e.lvl   = lvl;
    e.at    = at;
    e.cause = c;
    e.count = n;
    e.wdt   = w;
    sb.push_back(e);
  endtask

  // Monitor: every res_out transition must match the oldest expectation
  always @(negedge clock_160) begin
    if (mon_en && (rc_bus.res_out !== prev)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge res_out=%0b at cycle %0d, want no edge", rc_bus.res_out, cyc);
      end else begin
        cur = sb.pop_front();
        chk({cur.name, "_level"},     {31'b0, rc_bus.res_out},   {31'b0, cur.lvl});
        chk({cur.name, "_resn"},      {31'b0, rc_bus.resn_out},  {31'b0, ~cur.lvl});
        chk({cur.name, "_cycle"},     cyc,                       cur.at);
        chk({cur.name, "_cause"},     {30'b0, rc_bus.cause},     {30'b0, cur.cause});
        chk({cur.name, "_count"},     {24'b0, rc_bus.res_count}, {24'b0, cur.count});
        chk({cur.name, "_wdt_fired"}, {31'b0, rc_bus.wdt_fired}, {31'b0, cur.wdt});
      end
      prev = rc_bus.res_out;
    end
  end

  task automatic drain(input int unsigned limit);
    int unsigned n;
    exp_t d;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock_160);
      n++;
    end
    while (sb.size() != 0) begin
      d = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_timeout no res_out edge by cycle %0d, want edge at cycle %0d", d.name, cyc, d.at);
    end
    repeat (10) @(negedge clock_160);
  endtask

  // Pull source b active (low) for 'low' cycles; optionally expect a reset event
  task automatic src_pulse(input string nm, input int unsigned b, input int unsigned low,
                           input bit edges, input int unsigned rise_at, input int unsigned fall_at,
                           input logic [1:0] c, input logic w);
    int unsigned t0;
    @(negedge clock_160);
    t0 = cyc;
    if (edges) begin
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      expect_edge({nm, "_rise"}, 1'b1, t0 + rise_at, c, exp_cnt, w);
      expect_edge({nm, "_fall"}, 1'b0, t0 + fall_at, c, exp_cnt, w);
    end
    rc_bus.src_in[b] = 1'b0;
    repeat (low) @(negedge clock_160);
    rc_bus.src_in[b] = 1'b1;
  endtask

  task automatic release_reset(input string nm);
    int unsigned t0;
    @(negedge clock_160);
    t0 = cyc;
    expect_edge(nm, 1'b0, t0 + 11, 2'b00, 8'd0, 1'b0);
    #1 res = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    res              = 1'b1;
    rc_bus.src_in    = 2'b11;
    rc_bus.wdt_en    = 1'b0;
    rc_bus.wdt_kick  = 1'b0;
    exp_cnt          = 8'd0;

    // 1: reset values, then the POR pulse
    repeat (3) @(negedge clock_160);
    chk("rst_res_out",   {31'b0, rc_bus.res_out},   32'd1);
    chk("rst_resn_out",  {31'b0, rc_bus.resn_out},  32'd0);
    chk("rst_cause",     {30'b0, rc_bus.cause},     32'd0);
    chk("rst_count",     {24'b0, rc_bus.res_count}, 32'd0);
    chk("rst_wdt_fired", {31'b0, rc_bus.wdt_fired}, 32'd0);
    repeat (1) @(negedge clock_160);
    release_reset("t1_por_fall");
    drain(100);

    // 2: short glitch on debounced source is filtered; long one stretches
    src_pulse("t2_short", 0, 3, 1'b0, 0, 0, 2'b00, 1'b0);
    repeat (15) @(negedge clock_160);
    drain(100);
    src_pulse("t2_long", 0, 6, 1'b1, 7, 18, 2'b01, 1'b0);
    drain(100);

    // 3: bypass source follows the pin, no stretch
    src_pulse("t3_bypass", 1, 3, 1'b1, 3, 7, 2'b10, 1'b0);
    drain(100);

    // 4: long press holds reset until debounced release
    src_pulse("t4_hold", 0, 40, 1'b1, 7, 48, 2'b01, 1'b0);
    drain(100);

    // Debounced and bypass sources reaching the sequencer on the same cycle
    @(negedge clock_160);
    t0 = cyc;
    exp_cnt = exp_cnt + 8'd1;
    expect_edge("sim_rise", 1'b1, t0 + 7,  2'b11, exp_cnt, 1'b0);
    expect_edge("sim_fall", 1'b0, t0 + 18, 2'b11, exp_cnt, 1'b0);
    rc_bus.src_in[0] = 1'b0;
    repeat (4) @(negedge clock_160);
    rc_bus.src_in[1] = 1'b0;
    repeat (2) @(negedge clock_160);
    rc_bus.src_in[0] = 1'b1;
    repeat (2) @(negedge clock_160);
    rc_bus.src_in[1] = 1'b1;
    drain(100);

    // 5: counter saturation, then global reset clears everything
    for (int k = 0; k < 300; k++) begin
      src_pulse("t5_sat", 1, 2, 1'b1, 3, 6, 2'b10, 1'b0);
      repeat (6) @(negedge clock_160);
    end
    drain(100);
    chk("t5_count_saturated", {24'b0, rc_bus.res_count}, 32'd255);

    @(negedge clock_160);
    t0 = cyc;
    expect_edge("t5_res_assert", 1'b1, t0 + 1, 2'b00, 8'd0, 1'b0);
    #1 res = 1'b1;
    repeat (3) @(negedge clock_160);
    chk("t5_rst_count", {24'b0, rc_bus.res_count}, 32'd0);
    chk("t5_rst_cause", {30'b0, rc_bus.cause},     32'd0);
    exp_cnt = 8'd0;
    release_reset("t5_por_fall");
    drain(100);

`ifdef RESET_WDT_EN
    // 6: unkicked watchdog fires after 20 RUN cycles; regular kicks keep it quiet
    @(negedge clock_160);
    t0 = cyc;
    exp_cnt = exp_cnt + 8'd1;
    expect_edge("t6_wdt_rise", 1'b1, t0 + 20, 2'b00, exp_cnt, 1'b1);
    expect_edge("t6_wdt_fall", 1'b0, t0 + 31, 2'b00, exp_cnt, 1'b1);
    rc_bus.wdt_en = 1'b1;
    repeat (31) @(negedge clock_160);
    for (int k = 0; k < 20; k++) begin
      rc_bus.wdt_kick = 1'b1;
      @(negedge clock_160);
      rc_bus.wdt_kick = 1'b0;
      repeat (9) @(negedge clock_160);
    end
    rc_bus.wdt_en = 1'b0;
    drain(100);
`else
    // Without the watchdog, an enabled but unkicked watchdog does nothing
    rc_bus.wdt_en = 1'b1;
    repeat (60) @(negedge clock_160);
    rc_bus.wdt_en = 1'b0;
    drain(100);
`endif

    // A source-triggered reset leaves wdt_fired clear
    src_pulse("t6_src_after", 1, 2, 1'b1, 3, 6, 2'b10, 1'b0);
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
